fetch_queue: RTL and testbench

Instruction-fetch stage sitting directly downstream of the PC/next-address path. It takes the current PC and issues one word fetch at a time to instruction memory over a req/ack handshake. Each returned instruction is buffered with its PC in a small FIFO feeding decode over a valid/ready interface. A branch redirect flushes the buffered and in-flight fetches so that decode never sees wrong-path instructions.

---
 rtl/fetch_queue.sv | 151 +++++++++++++++
 tb/tb_fetch_queue.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: one outstanding imem fetch at a time, results buffered with their PC for decode.
// Optional FETCHQ_BYPASS_EN: an accepted word is forwarded to decode in the ack cycle when the FIFO is empty.
module fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] pc_in,
   input  logic        redirect,
   output logic        pc_advance,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          req_q, req_d;
   logic [63:0]   addr_q, addr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;

   logic [31:0]   instr_mem [DEPTH];
   logic [63:0]   pc_mem    [DEPTH];

   logic          accept;
   logic          fifo_empty;
   logic          bypass;
   logic          wr_en;
   logic          rd_en;

   assign accept     = (state_q == WAIT) && imem_ack && !redirect;
   assign fifo_empty = (count_q == '0);

`ifdef FETCHQ_BYPASS_EN
   assign bypass = accept && fifo_empty;
`else
   assign bypass = 1'b0;
`endif

   assign out_valid  = !fifo_empty || bypass;
   assign out_instr  = bypass ? imem_rdata : instr_mem[rd_ptr_q];
   assign out_pc     = bypass ? addr_q     : pc_mem[rd_ptr_q];

   // A bypassed word taken by decode in the same cycle never occupies a slot.
   assign wr_en      = accept && !(bypass && out_ready);
   assign rd_en      = !fifo_empty && out_ready;

   assign pc_advance = accept;
   assign imem_req   = req_q;
   assign imem_addr  = addr_q;

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      case (state_q)
         IDLE: begin
            // Issue only with a slot free, so the eventual push cannot overflow.
            if ((count_q < FULL) && !redirect) begin
               req_d   = 1'b1;
               addr_d  = pc_in;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (imem_ack) begin
               req_d   = 1'b0;
               state_d = IDLE;
            end else if (redirect) begin
               state_d = DROP;
            end
         end
         DROP: begin
            if (imem_ack) begin
               req_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            req_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (redirect) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         addr_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         addr_q   <= addr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         instr_mem[wr_ptr_q] <= imem_rdata;
         pc_mem[wr_ptr_q]    <= addr_q;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a latency-table memory responder, a PC register model,
// and a monitor that checks every word decode accepts against the expected queue.
module tb_fetch_queue;

   logic        clk;
   logic        rst;
   logic [63:0] pc_in;
   logic        redirect;
   logic        pc_advance;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;

   fetch_queue #(.DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .pc_in      (pc_in),
      .redirect   (redirect),
      .pc_advance (pc_advance),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .out_pc     (out_pc)
   );

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        exp_q[$];
   logic [63:0] iss_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          adv_cnt = 0;
   int          pop_cnt = 0;
   int          cnt = 0;
   int          fetch_idx = 0;
   int          lat_n = 0;
   int          lat_tab[8];
   logic [63:0] tgt = '0;
   logic [63:0] pc_reg;
   logic        req_prev = 1'b0;
   logic        found;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PC register upstream of the fetch stage
   always @(posedge clk) begin
      if (rst) pc_reg <= '0;
      else if (redirect) pc_reg <= tgt;
      else if (pc_advance) pc_reg <= pc_reg + 64'd4;
   end
   assign pc_in = pc_reg;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: event not seen within cycle budget", name);
   endtask

   task automatic push_exp(input logic [63:0] pc, input logic [31:0] instr);
      ent_t e;
      e.pc = pc;
      e.instr = instr;
      exp_q.push_back(e);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      redirect = 1'b0;
      out_ready = 1'b0;
      lat_n = 0;
      repeat (2) @(posedge clk);
      #2;
      exp_q.delete();
      iss_q.delete();
      adv_cnt = 0;
      pop_cnt = 0;
      fetch_idx = 0;
      rst = 1'b0;
   endtask

   // Memory: acks the n-th fetch after lat_tab[n] cycles of imem_req; fetches past lat_n never ack.
   initial begin
      imem_ack = 1'b0;
      imem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (imem_ack) fetch_idx++;
         if (rst || !imem_req) begin
            imem_ack = 1'b0;
            cnt = 0;
         end else begin
            cnt++;
            if (fetch_idx < lat_n && cnt == lat_tab[fetch_idx]) begin
               imem_ack = 1'b1;
               imem_rdata = {8'h13, imem_addr[23:0]};
            end else begin
               imem_ack = 1'b0;
            end
         end
      end
   end

   // Monitor: every accepted word is compared against the scoreboard head.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (pc_advance) adv_cnt++;
            if (imem_req && !req_prev) iss_q.push_back(imem_addr);
            if (out_valid && out_ready) begin
               pop_cnt++;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_pop: got pc 0x%0h instr 0x%0h, expected none", out_pc, out_instr);
               end else begin
                  ent_t e;
                  e = exp_q.pop_front();
                  check("pop_pc", out_pc, e.pc);
                  check("pop_instr", 64'(out_instr), 64'(e.instr));
               end
            end
         end
         req_prev = imem_req;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      redirect = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req", 64'(imem_req), 64'd0);
      check("rst_addr", imem_addr, 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_adv", 64'(pc_advance), 64'd0);
      check("rst_count", 64'(dut.count_q), 64'd0);
      check("rst_state", 64'(dut.state_q), 64'd0);

      // Basic fetch, 1-cycle ack, decode always ready
      do_reset();
      lat_tab[0] = 1; lat_tab[1] = 1; lat_n = 2;
      out_ready = 1'b1;
      push_exp(64'h0, 32'h13000000);
      push_exp(64'h4, 32'h13000004);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #2;
         if (imem_ack) begin found = 1'b1; break; end
      end
      if (!found) timeout("t1_ack");
      #1;
      check("t1_adv_on_ack", 64'(pc_advance), 64'd1);
`ifndef FETCHQ_BYPASS_EN
      check("t1_not_visible_at_ack", 64'(out_valid), 64'd0);
`endif
      wait_cycles(10);
      check("t1_sb_drained", 64'(exp_q.size()), 64'd0);
      check("t1_pops", 64'(pop_cnt), 64'd2);
      check("t1_adv_pulses", 64'(adv_cnt), 64'd2);
      check("t1_issues", 64'(iss_q.size()), 64'd3);
      if (iss_q.size() == 3) begin
         check("t1_addr0", iss_q[0], 64'h0);
         check("t1_addr1", iss_q[1], 64'h4);
         check("t1_addr2", iss_q[2], 64'h8);
      end

      // Backpressure: fill all 4 slots, then drain and resume at 0x10
      do_reset();
      for (int i = 0; i < 6; i++) lat_tab[i] = 1;
      lat_n = 6;
      out_ready = 1'b0;
      wait_cycles(14);
      check("t2_count_full", 64'(dut.count_q), 64'd4);
      check("t2_req_low", 64'(imem_req), 64'd0);
      check("t2_valid", 64'(out_valid), 64'd1);
      check("t2_head_pc", out_pc, 64'h0);
      check("t2_issues_full", 64'(iss_q.size()), 64'd4);
      wait_cycles(3);
      check("t2_req_still_low", 64'(imem_req), 64'd0);
      push_exp(64'h0,  32'h13000000);
      push_exp(64'h4,  32'h13000004);
      push_exp(64'h8,  32'h13000008);
      push_exp(64'hC,  32'h1300000C);
      push_exp(64'h10, 32'h13000010);
      push_exp(64'h14, 32'h13000014);
      out_ready = 1'b1;
      wait_cycles(20);
      check("t2_sb_drained", 64'(exp_q.size()), 64'd0);
      check("t2_pops", 64'(pop_cnt), 64'd6);
      check("t2_issues", 64'(iss_q.size()), 64'd7);
      if (iss_q.size() >= 5) check("t2_resume_addr", iss_q[4], 64'h10);

      // Redirect in WAIT before a late ack: DROP, discard, restart at 0x100
      do_reset();
      lat_tab[0] = 1; lat_tab[1] = 1; lat_tab[2] = 3; lat_tab[3] = 1; lat_n = 4;
      out_ready = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #2;
         if (fetch_idx == 2 && cnt == 1) begin found = 1'b1; break; end
      end
      if (!found) timeout("t3_wait_state");
      redirect = 1'b1;
      tgt = 64'h100;
      #1;
      check("t3_no_adv", 64'(pc_advance), 64'd0);
      @(posedge clk); #2;
      redirect = 1'b0;
      check("t3_state_drop", 64'(dut.state_q), 64'd2);
      check("t3_flushed_valid", 64'(out_valid), 64'd0);
      check("t3_flushed_count", 64'(dut.count_q), 64'd0);
      check("t3_req_held", 64'(imem_req), 64'd1);
      check("t3_addr_held", imem_addr, 64'h8);
      push_exp(64'h100, 32'h13000100);
      out_ready = 1'b1;
      wait_cycles(15);
      check("t3_sb_drained", 64'(exp_q.size()), 64'd0);
      check("t3_pops", 64'(pop_cnt), 64'd1);
      check("t3_adv_pulses", 64'(adv_cnt), 64'd3);
      check("t3_issues", 64'(iss_q.size()), 64'd5);
      if (iss_q.size() >= 4) check("t3_new_addr", iss_q[3], 64'h100);

      // Redirect coinciding with ack and a pop from a 2-entry FIFO
      do_reset();
      lat_tab[0] = 1; lat_tab[1] = 1; lat_tab[2] = 2; lat_tab[3] = 1; lat_n = 4;
      out_ready = 1'b0;
      push_exp(64'h0,   32'h13000000);
      push_exp(64'h200, 32'h13000200);
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #2;
         if (fetch_idx == 2 && imem_ack) begin found = 1'b1; break; end
      end
      if (!found) timeout("t4_ack");
      redirect = 1'b1;
      tgt = 64'h200;
      out_ready = 1'b1;
      #1;
      check("t4_count_before", 64'(dut.count_q), 64'd2);
      check("t4_no_adv", 64'(pc_advance), 64'd0);
      @(posedge clk); #2;
      redirect = 1'b0;
      check("t4_count_cleared", 64'(dut.count_q), 64'd0);
      check("t4_valid_cleared", 64'(out_valid), 64'd0);
      check("t4_pop_once", 64'(pop_cnt), 64'd1);
      wait_cycles(12);
      check("t4_sb_drained", 64'(exp_q.size()), 64'd0);
      check("t4_pops", 64'(pop_cnt), 64'd2);
      check("t4_adv_pulses", 64'(adv_cnt), 64'd3);
      if (iss_q.size() >= 4) check("t4_new_addr", iss_q[3], 64'h200);
      else timeout("t4_new_issue");

      // Reset while waiting for an ack, then a clean fetch
      do_reset();
      lat_tab[0] = 9; lat_n = 1;
      out_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #2;
         if (imem_req && cnt == 2) begin found = 1'b1; break; end
      end
      if (!found) timeout("t5_wait_state");
      rst = 1'b1;
      @(posedge clk); #2;
      check("t5_req_dropped", 64'(imem_req), 64'd0);
      check("t5_valid", 64'(out_valid), 64'd0);
      check("t5_state_idle", 64'(dut.state_q), 64'd0);
      exp_q.delete();
      iss_q.delete();
      adv_cnt = 0;
      pop_cnt = 0;
      fetch_idx = 0;
      lat_tab[0] = 1;
      rst = 1'b0;
      push_exp(64'h0, 32'h13000000);
      wait_cycles(8);
      check("t5_sb_drained", 64'(exp_q.size()), 64'd0);
      check("t5_pops", 64'(pop_cnt), 64'd1);
      if (iss_q.size() >= 1) check("t5_addr", iss_q[0], 64'h0);
      else timeout("t5_issue");

`ifdef FETCHQ_BYPASS_EN
      // Bypass: empty FIFO, ack and ready in the same cycle
      do_reset();
      lat_tab[0] = 1; lat_n = 1;
      out_ready = 1'b1;
      push_exp(64'h0, 32'h13000000);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #2;
         if (imem_ack) begin found = 1'b1; break; end
      end
      if (!found) timeout("t6_ack");
      #1;
      check("t6_valid_at_ack", 64'(out_valid), 64'd1);
      check("t6_pc_at_ack", out_pc, 64'h0);
      check("t6_instr_at_ack", 64'(out_instr), 64'h13000000);
      @(posedge clk); #2;
      check("t6_count_zero", 64'(dut.count_q), 64'd0);
      check("t6_pops", 64'(pop_cnt), 64'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
